// File: rtl/micro_sequencer.sv
// micro_sequencer: uPC register and 16-entry control store
// with memory-ready stall, illegal-dispatch recovery and instret.
module micro_sequencer #(
  parameter int CNT_W      = 32,
  parameter int LAST_STATE = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       nextAddr,
  input  logic             memReady,
  output logic [3:0]       currAddr,
  output logic [2:0]       addrCtl,
  output logic             adrSrc,
  output logic             irWrite,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       resultSrc,
  output logic             pcUpdate,
  output logic             regWrite,
  output logic             memWrite,
  output logic             branch,
  output logic             memReq,
  output logic             illegalOp,
  output logic [CNT_W-1:0] instret
);

  localparam logic [3:0] LAST = 4'(LAST_STATE);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXER   = 4'd6,
    S_ALUWB  = 4'd7,
    S_EXEI   = 4'd8,
    S_JAL    = 4'd9,
    S_BEQ    = 4'd10
  } state_t;

  logic [3:0]       r_upc;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;

  logic [3:0] w_upc_nxt;
  logic       w_ill;
  logic       w_ret;
  logic       w_stall;
  logic       w_ir;
  logic       w_pc;
  logic       w_mw;

  // Control store: Moore decode of the uPC.
  always_comb begin
    addrCtl   = 3'd3;
    adrSrc    = 1'b0;
    w_ir      = 1'b0;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    resultSrc = 2'b00;
    w_pc      = 1'b0;
    regWrite  = 1'b0;
    w_mw      = 1'b0;
    branch    = 1'b0;
    memReq    = 1'b0;
    unique case (r_upc)
      S_FETCH: begin
        w_ir      = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        w_pc      = 1'b1;
        memReq    = 1'b1;
        addrCtl   = 3'd0;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        addrCtl = 3'd1;
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        addrCtl = 3'd2;
      end
      S_MEMRD: begin
        adrSrc  = 1'b1;
        memReq  = 1'b1;
        addrCtl = 3'd0;
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
      end
      S_MEMWR: begin
        adrSrc = 1'b1;
        w_mw   = 1'b1;
        memReq = 1'b1;
      end
      S_EXER: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
        addrCtl = 3'd0;
      end
      S_ALUWB: regWrite = 1'b1;
      S_EXEI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 2'b10;
        addrCtl = 3'd4;
      end
      S_JAL: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        w_pc    = 1'b1;
        addrCtl = 3'd4;
      end
      S_BEQ: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b01;
        branch  = 1'b1;
      end
      default: addrCtl = 3'd3;
    endcase
  end

  assign w_stall  = memReq & ~memReady;
  assign irWrite  = w_ir & ~w_stall;
  assign pcUpdate = w_pc & ~w_stall;
  assign memWrite = w_mw & ~w_stall;

  // Next uPC, illegal-dispatch detect and retire qualifier.
  always_comb begin
    w_upc_nxt = r_upc;
    w_ill     = 1'b0;
    w_ret     = 1'b0;
    if (!w_stall) begin
      if (nextAddr > LAST) begin
        w_upc_nxt = 4'd0;
        w_ill     = 1'b1;
      end else begin
        w_upc_nxt = nextAddr;
      end
      w_ret = ~w_ill & ((r_upc == S_MEMWB) |
                        (r_upc == S_MEMWR) |
                        (r_upc == S_ALUWB) |
                        (r_upc == S_BEQ));
    end
  end

  // uPC, illegal pulse and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_upc     <= 4'd0;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      r_upc     <= w_upc_nxt;
      r_illegal <= w_ill;
      if (w_ret) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign currAddr  = r_upc;
  assign illegalOp = r_illegal;
  assign instret   = r_instret;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed bench with a behavioural
// next-address selector driving the sequencer.
module tb_micro_sequencer;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [17:0] CW_FETCH = {1'b0, 1'b1, 2'b00, 2'b10,
    2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
  localparam logic [17:0] CW_FETCH_ST = {1'b0, 1'b0, 2'b00, 2'b10,
    2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
  localparam logic [17:0] CW_DECODE = {1'b0, 1'b0, 2'b01, 2'b01,
    2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
  localparam logic [17:0] CW_MEMADR = {1'b0, 1'b0, 2'b10, 2'b01,
    2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
  localparam logic [17:0] CW_MEMRD = {1'b1, 1'b0, 2'b00, 2'b00,
    2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
  localparam logic [17:0] CW_MEMWB = {1'b0, 1'b0, 2'b00, 2'b00,
    2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
  localparam logic [17:0] CW_MEMWR = {1'b1, 1'b0, 2'b00, 2'b00,
    2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3};
  localparam logic [17:0] CW_MEMWR_ST = {1'b1, 1'b0, 2'b00, 2'b00,
    2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3};
  localparam logic [17:0] CW_EXER = {1'b0, 1'b0, 2'b10, 2'b00,
    2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
  localparam logic [17:0] CW_ALUWB = {1'b0, 1'b0, 2'b00, 2'b00,
    2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
  localparam logic [17:0] CW_BEQ = {1'b0, 1'b0, 2'b10, 2'b00,
    2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3};

  logic        clk;
  logic        reset;
  logic [3:0]  nextAddr;
  logic        memReady;
  logic [3:0]  currAddr;
  logic [2:0]  addrCtl;
  logic        adrSrc;
  logic        irWrite;
  logic [1:0]  aluSrcA;
  logic [1:0]  aluSrcB;
  logic [1:0]  aluOp;
  logic [1:0]  resultSrc;
  logic        pcUpdate;
  logic        regWrite;
  logic        memWrite;
  logic        branch;
  logic        memReq;
  logic        illegalOp;
  logic [31:0] instret;

  logic [6:0]  op;
  logic        force_en;
  logic [3:0]  force_val;
  logic [3:0]  sel;
  logic [17:0] cw;

  int n_run;
  int n_fail;
  int exp_ret;

  micro_sequencer #(.CNT_W(32), .LAST_STATE(10)) dut (
    .clk(clk), .reset(reset), .nextAddr(nextAddr),
    .memReady(memReady), .currAddr(currAddr),
    .addrCtl(addrCtl), .adrSrc(adrSrc), .irWrite(irWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .resultSrc(resultSrc), .pcUpdate(pcUpdate),
    .regWrite(regWrite), .memWrite(memWrite),
    .branch(branch), .memReq(memReq),
    .illegalOp(illegalOp), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural next-address selector.
  always_comb begin
    sel = 4'd0;
    case (addrCtl)
      3'd0: sel = currAddr + 4'd1;
      3'd1: begin
        case (op)
          OP_LW, OP_SW: sel = 4'd2;
          OP_R:         sel = 4'd6;
          OP_I:         sel = 4'd8;
          OP_JAL:       sel = 4'd9;
          OP_BEQ:       sel = 4'd10;
          default:      sel = 4'd14;
        endcase
      end
      3'd2: sel = (op == OP_SW) ? 4'd5 : 4'd3;
      3'd3: sel = 4'd0;
      3'd4: sel = 4'd7;
      default: sel = 4'd0;
    endcase
  end

  assign nextAddr = force_en ? force_val : sel;

  assign cw = {adrSrc, irWrite, aluSrcA, aluSrcB, aluOp,
               resultSrc, pcUpdate, regWrite, memWrite,
               branch, memReq, addrCtl};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    exp_ret   = 0;
    reset     = 1'b1;
    memReady  = 1'b1;
    op        = OP_R;
    force_en  = 1'b0;
    force_val = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_upc", 32'(currAddr), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_illegal", 32'(illegalOp), 32'd0);
    chk("rst_cw", 32'(cw), 32'(CW_FETCH));
    reset = 1'b0;

    // R-type: 0,1,6,7,0
    step();
    chk("r_upc1", 32'(currAddr), 32'd1);
    chk("r_cw_dec", 32'(cw), 32'(CW_DECODE));
    step();
    chk("r_upc6", 32'(currAddr), 32'd6);
    chk("r_cw_exe", 32'(cw), 32'(CW_EXER));
    step();
    chk("r_upc7", 32'(currAddr), 32'd7);
    chk("r_cw_wb", 32'(cw), 32'(CW_ALUWB));
    chk("r_ret_pre", instret, 32'd0);
    step();
    exp_ret = 1;
    chk("r_upc0", 32'(currAddr), 32'd0);
    chk("r_regwr0", 32'(regWrite), 32'd0);
    chk("r_ret", instret, 32'(exp_ret));

    // lw with three stalled edges in MemRead
    op = OP_LW;
    step();
    step();
    chk("lw_upc2", 32'(currAddr), 32'd2);
    chk("lw_cw_adr", 32'(cw), 32'(CW_MEMADR));
    step();
    chk("lw_upc3", 32'(currAddr), 32'd3);
    chk("lw_cw_rd", 32'(cw), 32'(CW_MEMRD));
    memReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lw_hold", 32'(currAddr), 32'd3);
      chk("lw_memreq", 32'(memReq), 32'd1);
    end
    memReady = 1'b1;
    step();
    chk("lw_upc4", 32'(currAddr), 32'd4);
    chk("lw_cw_wb", 32'(cw), 32'(CW_MEMWB));
    chk("lw_ret_pre", instret, 32'(exp_ret));
    step();
    exp_ret++;
    chk("lw_upc0", 32'(currAddr), 32'd0);
    chk("lw_ret", instret, 32'(exp_ret));

    // sw with two stalled cycles in MemWrite
    op = OP_SW;
    step();
    step();
    step();
    chk("sw_upc5", 32'(currAddr), 32'd5);
    memReady = 1'b0;
    #1;
    chk("sw_cw_stall", 32'(cw), 32'(CW_MEMWR_ST));
    step();
    chk("sw_hold1", 32'(currAddr), 32'd5);
    chk("sw_ret_hold", instret, 32'(exp_ret));
    step();
    chk("sw_hold2", 32'(currAddr), 32'd5);
    chk("sw_mw_stall", 32'(memWrite), 32'd0);
    memReady = 1'b1;
    #1;
    chk("sw_cw_ready", 32'(cw), 32'(CW_MEMWR));
    step();
    exp_ret++;
    chk("sw_upc0", 32'(currAddr), 32'd0);
    chk("sw_ret", instret, 32'(exp_ret));

    // Fetch stall
    op = OP_R;
    memReady = 1'b0;
    #1;
    chk("f_cw_stall", 32'(cw), 32'(CW_FETCH_ST));
    step();
    chk("f_hold1", 32'(currAddr), 32'd0);
    step();
    chk("f_hold2", 32'(currAddr), 32'd0);
    chk("f_irw_stall", 32'(irWrite), 32'd0);
    memReady = 1'b1;
    #1;
    chk("f_cw_ready", 32'(cw), 32'(CW_FETCH));
    step();
    chk("f_upc1", 32'(currAddr), 32'd1);

    // Illegal dispatch 14 from Decode
    force_val = 4'b1110;
    force_en  = 1'b1;
    step();
    force_en = 1'b0;
    chk("ill14_upc", 32'(currAddr), 32'd0);
    chk("ill14_pulse", 32'(illegalOp), 32'd1);
    chk("ill14_ret", instret, 32'(exp_ret));
    step();
    chk("ill14_upc1", 32'(currAddr), 32'd1);
    chk("ill14_clr", 32'(illegalOp), 32'd0);

    // Boundary: 11 is illegal
    force_val = 4'd11;
    force_en  = 1'b1;
    step();
    force_en = 1'b0;
    chk("ill11_upc", 32'(currAddr), 32'd0);
    chk("ill11_pulse", 32'(illegalOp), 32'd1);
    step();
    chk("ill11_clr", 32'(illegalOp), 32'd0);

    // Boundary: 10 (BEQ) is legal; memReady ignored there
    op = OP_BEQ;
    step();
    chk("beq_upc", 32'(currAddr), 32'd10);
    chk("beq_noill", 32'(illegalOp), 32'd0);
    chk("beq_cw", 32'(cw), 32'(CW_BEQ));
    memReady = 1'b0;
    step();
    exp_ret++;
    memReady = 1'b1;
    chk("beq_upc0", 32'(currAddr), 32'd0);
    chk("beq_ret", instret, 32'(exp_ret));

    // Asynchronous reset mid ExecuteR
    op = OP_R;
    step();
    step();
    chk("ar_upc6", 32'(currAddr), 32'd6);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_upc", 32'(currAddr), 32'd0);
    chk("ar_instret", instret, 32'd0);
    chk("ar_illegal", 32'(illegalOp), 32'd0);
    chk("ar_cw", 32'(cw), 32'(CW_FETCH));
    #1;
    reset = 1'b0;
    step();
    chk("ar_resume", 32'(currAddr), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram counter (uPC) register plus 16-entry control store for the multicycle microprogrammed RISC-V control unit.
- Sits directly downstream of the next-address selector: it registers `nextAddr` each cycle and feeds `currAddr` and `addrCtl` back to the selector.
- It also drives all datapath control strobes as a Moore function of uPC.
- It adds a memory-ready stall, illegal-dispatch recovery and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the `instret` counter.
- LAST_STATE, 10, highest legal microcode address; any higher `nextAddr` is treated as illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- nextAddr  in  4  next microaddress from the address selector.
- memReady  in  1  memory has completed the current access.
- currAddr  out  4  registered uPC, fed to the address selector.
- addrCtl  out  3  next-address mode: 0 = +1, 1 = dispatch1, 2 = dispatch2, 3 = fetch (0), 4 = goto 7.
- adrSrc  out  1  memory address select.
- irWrite  out  1  instruction register write enable.
- aluSrcA  out  2  ALU operand A select.
- aluSrcB  out  2  ALU operand B select.
- aluOp  out  2  ALU operation class.
- resultSrc  out  2  result mux select.
- pcUpdate  out  1  PC write enable.
- regWrite  out  1  register file write enable.
- memWrite  out  1  memory write enable.
- branch  out  1  branch evaluation enable.
- memReq  out  1  a memory access is in progress this state.
- illegalOp  out  1  one-cycle pulse: a dispatch went out of range.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (asynchronous, any time, including mid-instruction):
  - uPC = 0, illegalOp = 0, instret = 0.
  - Outputs immediately reflect state 0 (Fetch) decoding.
- Control word:
  - All control outputs are combinational from uPC only (Moore); there is no op input.
  - Unlisted fields are 0.
- Control store, format "state: fields; addrCtl":
  - 0 Fetch: irWrite, aluSrcB=10, resultSrc=10, pcUpdate, memReq; addrCtl=0.
  - 1 Decode: aluSrcA=01, aluSrcB=01; addrCtl=1.
  - 2 MemAdr: aluSrcA=10, aluSrcB=01; addrCtl=2.
  - 3 MemRead: adrSrc, memReq; addrCtl=0.
  - 4 MemWB: resultSrc=01, regWrite; addrCtl=3.
  - 5 MemWrite: adrSrc, memWrite, memReq; addrCtl=3.
  - 6 ExecuteR: aluSrcA=10, aluOp=10; addrCtl=0.
  - 7 ALUWB: regWrite; addrCtl=3.
  - 8 ExecuteI: aluSrcA=10, aluSrcB=01, aluOp=10; addrCtl=4.
  - 9 JAL: aluSrcA=01, aluSrcB=10, pcUpdate; addrCtl=4.
  - 10 BEQ: aluSrcA=10, aluOp=01, branch; addrCtl=3.
  - 11-15: all zero; addrCtl=3.
- Stall:
  - When memReq=1 and memReady=0, uPC holds.
  - During a stall, irWrite, pcUpdate and memWrite are forced 0.
  - All other fields remain as decoded.
  - Stall length is unbounded.
  - memReady is ignored when memReq=0.
- Advance: when not stalled, uPC <= nextAddr on each rising edge.
- Illegal dispatch:
  - Applies when not stalled and nextAddr > LAST_STATE.
  - uPC <= 0 (Fetch), not nextAddr.
  - illegalOp is set to 1 for exactly the following cycle.
  - instret does not increment.
- Unused states: if uPC somehow reaches 11-15, the next edge goes to 0 via addrCtl=3, with no illegalOp pulse.
- Retire:
  - instret increments by 1 on an edge where uPC is in {4, 5, 7, 10} and not stalled.
  - State 5 is non-stalled only with memReady=1.
  - instret wraps modulo 2^CNT_W with no saturation.
- Latency:
  - nextAddr to currAddr: 1 cycle.
  - currAddr to control outputs: 0 cycles.

Test Plan:
- Reset release, nextAddr driven from a behavioural address selector, op=0110011 (R-type), memReady=1:
  - uPC sequence 0,1,6,7,0.
  - regWrite=1 only in state 7.
  - instret=1 after the fourth edge.
- lw with memReady held 0 for 3 cycles in state 3:
  - uPC sequence 0,1,2,3,3,3,3,4,0.
  - memReq=1 throughout state 3.
  - instret=1 at end.
- sw with memReady=0 for 2 cycles in state 5:
  - memWrite=0 during the stall, 1 in the ready cycle.
  - uPC returns to 0.
  - instret increments exactly once.
- Fetch stall with memReady=0 for 2 cycles:
  - irWrite=0 and pcUpdate=0 while stalled.
  - uPC stays 0, then goes to 1 when memReady=1 with irWrite=1 and pcUpdate=1 that cycle.
- Force nextAddr=4'b1110 in Decode:
  - uPC goes to 0.
  - illegalOp=1 for one cycle.
  - instret unchanged.
- Assert reset asynchronously mid-state 6, between edges:
  - currAddr=0 immediately, instret=0, illegalOp=0.
  - Fetch control word is present before the next clock edge.
